// File: rtl/execute_md.sv
// Execute stage with single-cycle ALU plus an iterative RV32M multiply unit; the
// optional restoring divider is compiled in when EXE_DIV_EN is defined.
module execute_md #(
    parameter int N   = 32,
    parameter int BPC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         regEn,
    input  logic         in_valid,
    input  logic [N-1:0] NPCin,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] Imm,
    input  logic         muxSel,
    input  logic [4:0]   aluControl,
    output logic         busy,
    output logic         out_valid,
    output logic [N-1:0] NPCbranch,
    output logic [N-1:0] ALUres,
    output logic [N-1:0] Bout,
    output logic         zero
);
    localparam int ITER = N / BPC;
    localparam int CW   = $clog2(ITER + 1);
    localparam int SW   = $clog2(N);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nx;

    logic [N-1:0]    op2, alu_res, a_mag, b_mag;
    logic [SW-1:0]   shamt;
    logic            is_mul, is_div, is_multi, a_signed, b_signed, a_neg, b_neg;
    logic [N-1:0]    acc, lo, mb, acc_nx, lo_nx, fin;
    logic [N:0]      sum;
    logic [2*N-1:0]  prod, prod_s;
    logic [1:0]      op_code;
    logic            neg, last;
    logic [CW-1:0]   cnt;
`ifdef EXE_DIV_EN
    logic            op_div, neg_r, div0;
    logic [N-1:0]    orig_a, quo, rem;
    logic [N:0]      sh;
`endif

    assign op2      = muxSel ? Imm : B;
    assign shamt    = op2[SW-1:0];
    assign is_mul   = (aluControl[4:2] == 3'b100);
`ifdef EXE_DIV_EN
    assign is_div   = (aluControl[4:2] == 3'b101);
`else
    assign is_div   = 1'b0;
`endif
    assign is_multi = is_mul | is_div;
    assign busy     = (state == S_RUN);
    assign last     = (cnt == CW'(1));

    // mul/mulh treat both operands as signed, mulhsu only A; div/rem signed on even codes.
    assign a_signed = is_mul ? (aluControl[1:0] != 2'b11) : ~aluControl[0];
    assign b_signed = is_mul ? ~aluControl[1] : ~aluControl[0];
    assign a_neg    = a_signed & A[N-1];
    assign b_neg    = b_signed & op2[N-1];
    assign a_mag    = a_neg ? -A : A;
    assign b_mag    = b_neg ? -op2 : op2;

    always_comb begin
        alu_res = '0;
        case (aluControl)
            5'b00001: alu_res = A + op2;
            5'b00010: alu_res = A - op2;
            5'b00011: alu_res = A & op2;
            5'b00100: alu_res = A | op2;
            5'b00101: alu_res = A ^ op2;
            5'b00110: alu_res = A << shamt;
            5'b00111: alu_res = A >> shamt;
            5'b01000: alu_res = $signed(A) >>> shamt;
            5'b01001: alu_res = {{(N-1){1'b0}}, $signed(A) < $signed(op2)};
            5'b01010: alu_res = {{(N-1){1'b0}}, A < op2};
            5'b01011: alu_res = {{(N-1){1'b0}}, $signed(A) <= $signed(op2)};
            5'b01100: alu_res = {{(N-1){1'b0}}, A == op2};
            default:  alu_res = '0;
        endcase
    end

    // BPC sub-steps per cycle on the shared {acc, lo} pair: shift-add for
    // multiply (lo holds the multiplier), restoring division otherwise.
    always_comb begin
        acc_nx = acc;
        lo_nx  = lo;
        sum    = '0;
`ifdef EXE_DIV_EN
        sh     = '0;
`endif
        for (int i = 0; i < BPC; i++) begin
`ifdef EXE_DIV_EN
            if (op_div) begin
                sh    = {acc_nx, lo_nx[N-1]};
                lo_nx = {lo_nx[N-2:0], 1'b0};
                if (sh >= {1'b0, mb}) begin
                    sh       = sh - {1'b0, mb};
                    lo_nx[0] = 1'b1;
                end
                acc_nx = sh[N-1:0];
            end else begin
`endif
                sum    = {1'b0, acc_nx} + (lo_nx[0] ? {1'b0, mb} : {(N+1){1'b0}});
                acc_nx = sum[N:1];
                lo_nx  = {sum[0], lo_nx[N-1:1]};
`ifdef EXE_DIV_EN
            end
`endif
        end
    end

    assign prod   = {acc_nx, lo_nx};
    assign prod_s = neg ? -prod : prod;

`ifdef EXE_DIV_EN
    // Divide by zero bypasses the sign fix-up; signed overflow falls out naturally.
    assign quo = div0 ? {N{1'b1}} : (neg ? -lo_nx : lo_nx);
    assign rem = div0 ? orig_a : (neg_r ? -acc_nx : acc_nx);
    assign fin = op_div ? (op_code[1] ? rem : quo)
                        : ((op_code == 2'b00) ? prod_s[N-1:0] : prod_s[2*N-1:N]);
`else
    assign fin = (op_code == 2'b00) ? prod_s[N-1:0] : prod_s[2*N-1:N];
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (regEn && in_valid && is_multi) state_nx = S_RUN;
            S_RUN:   if (regEn && last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            NPCbranch <= '0;
            ALUres    <= '0;
            Bout      <= '0;
            zero      <= 1'b0;
            acc       <= '0;
            lo        <= '0;
            mb        <= '0;
            neg       <= 1'b0;
            op_code   <= '0;
            cnt       <= '0;
`ifdef EXE_DIV_EN
            op_div    <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
            orig_a    <= '0;
`endif
        end else if (regEn) begin
            out_valid <= 1'b0;
            if (state == S_IDLE && in_valid) begin
                NPCbranch <= NPCin + Imm;
                Bout      <= B;
                if (is_multi) begin
                    acc     <= '0;
                    lo      <= a_mag;
                    mb      <= b_mag;
                    neg     <= a_neg ^ b_neg;
                    op_code <= aluControl[1:0];
                    cnt     <= CW'(ITER);
`ifdef EXE_DIV_EN
                    op_div  <= is_div;
                    neg_r   <= a_neg;
                    div0    <= (op2 == '0);
                    orig_a  <= A;
`endif
                end else begin
                    ALUres    <= alu_res;
                    zero      <= (alu_res == '0);
                    out_valid <= 1'b1;
                end
            end else if (state == S_RUN) begin
                acc <= acc_nx;
                lo  <= lo_nx;
                cnt <= cnt - CW'(1);
                if (last) begin
                    ALUres    <= fin;
                    zero      <= (fin == '0);
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised successor to the single-cycle execute stage.
- Keeps the ALU, branch-target adder and B pass-through.
- Adds an iterative multiply unit (RV32M MUL/MULH/MULHSU/MULHU) and, optionally, a divide unit, with a valid/busy handshake so decode can stall.
- Sits between the ID/EX and EX/MEM boundaries; all outputs are registered.

Parameters:
- N, 32: datapath width; must be a multiple of BPC.
- BPC, 1: multiplier/divider bits retired per cycle; must be 1, 2 or 4. Iteration count ITER = N/BPC.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-low
- regEn  in  1  stage enable; 0 freezes every register
- in_valid  in  1  operation presented this cycle
- NPCin  in  N  PC of the instruction
- A  in  N  operand rs1
- B  in  N  operand rs2
- Imm  in  N  immediate
- muxSel  in  1  second operand select: 1=Imm, 0=B
- aluControl  in  5  operation code (see Behaviour)
- busy  out  1  multi-cycle op in flight; inputs ignored
- out_valid  out  1  result registers loaded this cycle
- NPCbranch  out  N  NPCin+Imm, modulo 2^N
- ALUres  out  N  result
- Bout  out  N  captured B
- zero  out  1  ALUres==0

Behaviour:
- Reset (rst=0 at an edge, regardless of regEn): all outputs 0, busy=0, iteration counter 0. A reset while busy aborts the operation; no out_valid follows.
- Operand: OP2 = muxSel ? Imm : B.
- Single-cycle codes:
  - 00001 add; 00010 sub; 00011 and; 00100 or; 00101 xor.
  - 00110 sll, 00111 srl, 01000 sra: shift amount OP2[log2(N)-1:0].
  - 01001 slt, signed; 01010 sltu.
  - 01011 leq, signed A<=OP2; 01100 eq.
  - Compare codes produce 0 or 1 in bit 0.
  - Any other code not listed under multi-cycle codes gives ALUres=0.
- Multi-cycle codes:
  - 10000 mul (low N); 10001 mulh (s×s high N); 10010 mulhsu (s×u high); 10011 mulhu (u×u high).
  - 10100 div; 10101 divu; 10110 rem; 10111 remu.
- Accept: an edge with regEn=1, in_valid=1, busy=0 and rst=1. NPCin+Imm and B are captured at accept into NPCbranch and Bout.
- Single-cycle op: ALUres, zero, NPCbranch and Bout load at the accept edge. out_valid=1 for that cycle.
- Multi-cycle op: at accept, busy goes to 1; operands are latched after sign-magnitude conversion; the counter loads ITER.
  - Each enabled edge retires BPC bits.
  - After ITER further enabled edges, results load, out_valid=1 for one cycle and busy=0 on the same edge.
  - Accept-to-result: ITER+1 edges.
  - A new op may be accepted on the edge after busy falls.
- out_valid is 0 on every edge without a result load, except as noted for regEn=0.
- regEn=0: every register holds, including the counter, busy and out_valid; the iteration stalls.
- in_valid while busy=1: ignored; no queueing.
- Multiplier: N+N-bit product formed by shift-add over ITER steps. Signed operands are handled via magnitudes with the result negated when the signs differ.
- Divider, when present, is a restoring divider with one quotient bit per sub-step and BPC sub-steps per cycle. Result sign follows the RISC-V rules.
  - Divide by zero: quotient all-ones (divu and div); remainder = dividend.
  - Signed overflow (-2^(N-1) / -1): quotient = dividend, remainder 0.
  - Both cases still take the full ITER+1 latency.
- zero is computed from the value loaded into ALUres on the same edge.

Optional Feature:
- EXE_DIV_EN defined: the divider is present and codes 10100–10111 behave as above.
- EXE_DIV_EN undefined: no divider logic. Codes 10100–10111 are treated as single-cycle with ALUres=0, zero=1 and out_valid at the accept edge; busy never asserts for them.

Test Plan:
- addi: NPCin=0x400004, A=0x1fc18, Imm=0x10, muxSel=1, code 00001 → next edge: ALUres=0x1fc28, NPCbranch=0x400014, out_valid=1 for one cycle.
- sub/leq: A=0x21d, B=0x266, muxSel=0.
  - sub → ALUres=0xFFFFFFB7.
  - leq → ALUres=1, zero=0.
  - Swapped operands, leq → ALUres=0, zero=1.
- mul, BPC=1: A=0x266, B=0x21d → busy high for 32 cycles; ALUres=0x5118E, out_valid on edge 33. in_valid pulses during busy produce no extra out_valid.
- mulhu: A=B=0xFFFFFFFF → ALUres=0xFFFFFFFE. Hold regEn=0 for 5 cycles mid-op → result arrives 5 cycles later, value unchanged.
- EXE_DIV_EN set:
  - divu 0x266/0x21d → 1; remu → 0x49.
  - div 7/0 → 0xFFFFFFFF; rem 7/0 → 7.
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
- Drive rst=0 for one edge at iteration 10 of a mul → busy=0 and outputs 0 next cycle; no out_valid; the next add completes normally.
